// File: rtl/dmem_bus_arbiter.sv
// Shares the single main-memory port between dcache and icache, tracks tag ownership, and routes fills back to their owner.
// Optional build macro ARB_ROUND_ROBIN_EN selects round-robin arbitration instead of fixed dcache priority with a starvation escape.
module dmem_bus_arbiter #(
  parameter int NUM_MEM_TAGS = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  dcache2mem_command,
  input  logic [31:0] dcache2mem_addr,
  input  logic [63:0] dcache2mem_data,
  input  logic [1:0]  icache2mem_command,
  input  logic [31:0] icache2mem_addr,
  input  logic [3:0]  mem2arb_response,
  input  logic [63:0] mem2arb_data,
  input  logic [3:0]  mem2arb_tag,
  output logic [1:0]  arb2mem_command,
  output logic [31:0] arb2mem_addr,
  output logic [63:0] arb2mem_data,
  output logic [3:0]  mem2dcache_response,
  output logic [3:0]  mem2icache_response,
  output logic [63:0] mem2dcache_data,
  output logic [3:0]  mem2dcache_tag,
  output logic [63:0] mem2icache_data,
  output logic [3:0]  mem2icache_tag,
  output logic [4:0]  arb_outstanding,
  output logic        arb_err
);
  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;

  logic d_req, i_req, grant_d, grant_i;
  logic [NUM_MEM_TAGS-1:0] valid_q, valid_d, owner_q, owner_d;
  logic       err_q, err_d;
  logic [4:0] outstanding_q, outstanding_d;
  logic       ret_hit, ret_owner;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_last_q, rr_last_d;
`else
  logic [2:0] starve_q, starve_d;
`endif

  always_comb begin
    d_req = (dcache2mem_command != BUS_NONE);
    i_req = (icache2mem_command != BUS_NONE);
`ifdef ARB_ROUND_ROBIN_EN
    // On conflict the requester that did not win last time goes first.
    grant_i = i_req && (!d_req || !rr_last_q);
`else
    grant_i = i_req && (!d_req || (starve_q == 3'(STARVE_LIMIT)));
`endif
    grant_d = d_req && !grant_i;
  end

  always_comb begin
    arb2mem_command = BUS_NONE;
    arb2mem_addr    = 32'd0;
    arb2mem_data    = 64'd0;
    if (grant_d) begin
      arb2mem_command = dcache2mem_command;
      arb2mem_addr    = dcache2mem_addr;
      arb2mem_data    = dcache2mem_data;
    end else if (grant_i) begin
      arb2mem_command = icache2mem_command;
      arb2mem_addr    = icache2mem_addr;
    end
    mem2dcache_response = grant_d ? mem2arb_response : 4'd0;
    mem2icache_response = grant_i ? mem2arb_response : 4'd0;
  end

  // Return routing uses the table as it stood before this cycle's acceptance.
  always_comb begin
    ret_hit   = (mem2arb_tag != 4'd0) && valid_q[mem2arb_tag];
    ret_owner = owner_q[mem2arb_tag];
    mem2dcache_data = (ret_hit && !ret_owner) ? mem2arb_data : 64'd0;
    mem2dcache_tag  = (ret_hit && !ret_owner) ? mem2arb_tag  : 4'd0;
    mem2icache_data = (ret_hit &&  ret_owner) ? mem2arb_data : 64'd0;
    mem2icache_tag  = (ret_hit &&  ret_owner) ? mem2arb_tag  : 4'd0;
  end

  always_comb begin
    valid_d = valid_q;
    owner_d = owner_q;
    err_d   = err_q;
    if (mem2arb_tag != 4'd0) begin
      if (valid_q[mem2arb_tag]) valid_d[mem2arb_tag] = 1'b0;
      else                      err_d = 1'b1;
    end
    // Applied after the clear so a same-tag reissue keeps the new owner.
    if (arb2mem_command == BUS_LOAD && mem2arb_response != 4'd0) begin
      valid_d[mem2arb_response] = 1'b1;
      owner_d[mem2arb_response] = grant_i;
    end
    outstanding_d = 5'd0;
    for (int i = 0; i < NUM_MEM_TAGS; i++) outstanding_d = outstanding_d + 5'(valid_d[i]);
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    rr_last_d = rr_last_q;
    if ((grant_d || grant_i) && mem2arb_response != 4'd0) rr_last_d = grant_i;
  end
`else
  always_comb begin
    starve_d = 3'd0;
    if (i_req && !grant_i)
      starve_d = (starve_q == 3'(STARVE_LIMIT)) ? starve_q : starve_q + 3'd1;
  end
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q       <= '0;
      owner_q       <= '0;
      err_q         <= 1'b0;
      outstanding_q <= 5'd0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_last_q     <= 1'b0;
`else
      starve_q      <= 3'd0;
`endif
    end else begin
      valid_q       <= valid_d;
      owner_q       <= owner_d;
      err_q         <= err_d;
      outstanding_q <= outstanding_d;
`ifdef ARB_ROUND_ROBIN_EN
      rr_last_q     <= rr_last_d;
`else
      starve_q      <= starve_d;
`endif
    end
  end

  assign arb_outstanding = outstanding_q;
  assign arb_err         = err_q;
endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Directed bench for dmem_bus_arbiter: a tag-ownership model checked every cycle plus literal spot checks.
module tb_dmem_bus_arbiter;
  localparam logic [1:0] NONE = 2'd0, LOAD = 2'd1, STORE = 2'd2;
  localparam int LIMIT = 4;

  logic        clock, reset;
  logic [1:0]  dcache2mem_command, icache2mem_command;
  logic [31:0] dcache2mem_addr, icache2mem_addr;
  logic [63:0] dcache2mem_data, mem2arb_data;
  logic [3:0]  mem2arb_response, mem2arb_tag;
  logic [1:0]  arb2mem_command;
  logic [31:0] arb2mem_addr;
  logic [63:0] arb2mem_data, mem2dcache_data, mem2icache_data;
  logic [3:0]  mem2dcache_response, mem2icache_response, mem2dcache_tag, mem2icache_tag;
  logic [4:0]  arb_outstanding;
  logic        arb_err;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 0;

  dmem_bus_arbiter #(.NUM_MEM_TAGS(16), .STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .dcache2mem_command(dcache2mem_command), .dcache2mem_addr(dcache2mem_addr),
    .dcache2mem_data(dcache2mem_data),
    .icache2mem_command(icache2mem_command), .icache2mem_addr(icache2mem_addr),
    .mem2arb_response(mem2arb_response), .mem2arb_data(mem2arb_data), .mem2arb_tag(mem2arb_tag),
    .arb2mem_command(arb2mem_command), .arb2mem_addr(arb2mem_addr), .arb2mem_data(arb2mem_data),
    .mem2dcache_response(mem2dcache_response), .mem2icache_response(mem2icache_response),
    .mem2dcache_data(mem2dcache_data), .mem2dcache_tag(mem2dcache_tag),
    .mem2icache_data(mem2icache_data), .mem2icache_tag(mem2icache_tag),
    .arb_outstanding(arb_outstanding), .arb_err(arb_err)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns each tag (-1 = nobody), who won last, how long icache waited.
  int  owner_m [16];
  int  denials_m = 0;
  int  last_i_m = 0;
  bit  err_m = 0;

  always @(negedge clock) begin
    bit d_req, i_req, i_wins, d_wins;
    logic [1:0] e_cmd; logic [31:0] e_addr; logic [63:0] e_data;
    int cnt, rt, rs;
    if (cmp_en) begin
      d_req = dcache2mem_command != NONE;
      i_req = icache2mem_command != NONE;
`ifdef ARB_ROUND_ROBIN_EN
      i_wins = i_req && (!d_req || last_i_m == 0);
`else
      i_wins = i_req && (!d_req || denials_m >= LIMIT);
`endif
      d_wins = d_req && !i_wins;
      e_cmd  = d_wins ? dcache2mem_command : (i_wins ? icache2mem_command : NONE);
      e_addr = d_wins ? dcache2mem_addr : (i_wins ? icache2mem_addr : 32'd0);
      e_data = d_wins ? dcache2mem_data : 64'd0;
      rt = int'(mem2arb_tag);
      rs = int'(mem2arb_response);
      cnt = 0;
      foreach (owner_m[k]) if (owner_m[k] >= 0) cnt++;
      chk("m_cmd", arb2mem_command, e_cmd);
      chk("m_addr", arb2mem_addr, e_addr);
      chk("m_data", arb2mem_data, e_data);
      chk("m_dresp", mem2dcache_response, d_wins ? rs : 0);
      chk("m_iresp", mem2icache_response, i_wins ? rs : 0);
      chk("m_dtag", mem2dcache_tag, (rt != 0 && owner_m[rt] == 0) ? rt : 0);
      chk("m_ddata", mem2dcache_data, (rt != 0 && owner_m[rt] == 0) ? mem2arb_data : 64'd0);
      chk("m_itag", mem2icache_tag, (rt != 0 && owner_m[rt] == 1) ? rt : 0);
      chk("m_idata", mem2icache_data, (rt != 0 && owner_m[rt] == 1) ? mem2arb_data : 64'd0);
      chk("m_outst", arb_outstanding, cnt);
      chk("m_err", arb_err, err_m);
      // Advance the model to the state after the coming edge.
      if (!reset) begin
        foreach (owner_m[k]) owner_m[k] = -1;
        denials_m = 0; last_i_m = 0; err_m = 0;
      end else begin
        if (rt != 0) begin
          if (owner_m[rt] >= 0) owner_m[rt] = -1;
          else err_m = 1;
        end
        if (e_cmd == LOAD && rs != 0) owner_m[rs] = i_wins ? 1 : 0;
        if ((d_wins || i_wins) && rs != 0) last_i_m = i_wins ? 1 : 0;
        if (i_req && !i_wins) denials_m = (denials_m >= LIMIT) ? LIMIT : denials_m + 1;
        else denials_m = 0;
      end
    end
  end

  // driver tasks
  task automatic drive(input logic [1:0] dc, input logic [31:0] da, input logic [63:0] dd,
                       input logic [1:0] ic, input logic [31:0] ia, input logic [3:0] resp,
                       input logic [3:0] rtag, input logic [63:0] rdata);
    @(posedge clock); #1;
    dcache2mem_command = dc; dcache2mem_addr = da; dcache2mem_data = dd;
    icache2mem_command = ic; icache2mem_addr = ia;
    mem2arb_response = resp; mem2arb_tag = rtag; mem2arb_data = rdata;
    #1;
  endtask

  task automatic idle();
    drive(NONE, 0, 0, NONE, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b0;
    idle();
    @(posedge clock); #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] exp_addr [6];
    foreach (owner_m[k]) owner_m[k] = -1;
    reset = 1'b0;
    dcache2mem_command = NONE; dcache2mem_addr = 0; dcache2mem_data = 0;
    icache2mem_command = NONE; icache2mem_addr = 0;
    mem2arb_response = 0; mem2arb_tag = 0; mem2arb_data = 0;
    @(posedge clock);
    cmp_en = 1;
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    chk("rst_outst", arb_outstanding, 0);
    chk("rst_err", arb_err, 0);

    // dcache load accepted with tag 3, then tag 3 returns
    drive(LOAD, 32'h100, 0, NONE, 0, 4'd3, 0, 0);
    chk("t1_addr", arb2mem_addr, 32'h100);
    chk("t1_dresp", mem2dcache_response, 3);
    chk("t1_iresp", mem2icache_response, 0);
    idle();
    chk("t1_outst", arb_outstanding, 1);
    drive(NONE, 0, 0, NONE, 0, 0, 4'd3, 64'hDEAD);
    chk("t2_ddata", mem2dcache_data, 64'hDEAD);
    chk("t2_dtag", mem2dcache_tag, 3);
    chk("t2_itag", mem2icache_tag, 0);
    idle();
    chk("t2_outst", arb_outstanding, 0);

`ifdef ARB_ROUND_ROBIN_EN
    // conflict alternates I,D,I,D from reset, reset clears the history
    exp_addr = '{32'h2000, 32'h1001, 32'h2002, 32'h1003, 32'h2004, 32'h1005};
    for (int k = 0; k < 6; k++) begin
      drive(LOAD, 32'h1000 + k, 0, LOAD, 32'h2000 + k, 4'(k + 1), 0, 0);
      chk("t6_addr", arb2mem_addr, exp_addr[k]);
    end
    idle();
    chk("t6_outst", arb_outstanding, 6);
    do_reset();
    #1;
    chk("t6_rst_outst", arb_outstanding, 0);
    drive(LOAD, 32'h1010, 0, LOAD, 32'h2010, 4'd7, 0, 0);
    chk("t6_rst_grant", arb2mem_addr, 32'h2010);
    chk("t6_rst_iresp", mem2icache_response, 7);
    drive(NONE, 0, 0, NONE, 0, 0, 4'd7, 64'h77);
    chk("t6_ret_itag", mem2icache_tag, 7);
`else
    // both request: D,D,D,D then icache escapes starvation; sixth is rejected
    exp_addr = '{32'h1000, 32'h1001, 32'h1002, 32'h1003, 32'h2004, 32'h1005};
    for (int k = 0; k < 6; k++) begin
      drive(LOAD, 32'h1000 + k, 0, LOAD, 32'h2000 + k, (k < 5) ? 4'(k + 1) : 4'd0, 0, 0);
      chk("t3_addr", arb2mem_addr, exp_addr[k]);
    end
    idle();
    chk("t3_outst", arb_outstanding, 5);
    for (int k = 1; k <= 5; k++) begin
      drive(NONE, 0, 0, NONE, 0, 0, 4'(k), 64'h500 + k);
      chk("t3_itag", mem2icache_tag, (k == 5) ? 4'd5 : 4'd0);
      chk("t3_dtag", mem2dcache_tag, (k == 5) ? 4'd0 : 4'(k));
    end
`endif
    idle();
    chk("t3_outst0", arb_outstanding, 0);

    // store is forwarded but never recorded
    drive(STORE, 32'h200, 64'h55, NONE, 0, 4'd7, 0, 0);
    chk("t4_data", arb2mem_data, 64'h55);
    chk("t4_cmd", arb2mem_command, STORE);
    idle();
    chk("t4_outst", arb_outstanding, 0);

    // tag 4 reissued to icache while its dcache fill returns
    drive(LOAD, 32'h300, 0, NONE, 0, 4'd4, 0, 0);
    drive(NONE, 0, 0, LOAD, 32'h400, 4'd4, 4'd4, 64'hAA);
    chk("col_dtag", mem2dcache_tag, 4);
    chk("col_ddata", mem2dcache_data, 64'hAA);
    chk("col_itag", mem2icache_tag, 0);
    chk("col_iresp", mem2icache_response, 4);
    drive(NONE, 0, 0, NONE, 0, 0, 4'd4, 64'hBB);
    chk("col2_itag", mem2icache_tag, 4);
    chk("col2_idata", mem2icache_data, 64'hBB);
    chk("col2_dtag", mem2dcache_tag, 0);
    idle();
    chk("col_outst", arb_outstanding, 0);
    chk("col_err", arb_err, 0);

    // unowned tag raises a sticky error
    drive(NONE, 0, 0, NONE, 0, 0, 4'd9, 64'h99);
    chk("t5_dtag", mem2dcache_tag, 0);
    chk("t5_itag", mem2icache_tag, 0);
    for (int k = 0; k < 3; k++) begin
      idle();
      chk("t5_err", arb_err, 1);
    end
    do_reset();
    #1;
    chk("t5_err_clr", arb_err, 0);

    // reset with a fill in flight drops it and flags the late return
    drive(LOAD, 32'h500, 0, NONE, 0, 4'd2, 0, 0);
    do_reset();
    #1;
    chk("mid_outst", arb_outstanding, 0);
    drive(NONE, 0, 0, NONE, 0, 0, 4'd2, 64'h22);
    chk("mid_dtag", mem2dcache_tag, 0);
    idle();
    chk("mid_err", arb_err, 1);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
